// File: rtl/ps2_keys_pkg.sv
// Shared constants and types for the PS/2 key tracker: scan-code bytes,
// prefix-tracking FSM states and keyboard geometry.
package ps2_keys_pkg;

    localparam int NUM_KEYS = 88;
    localparam logic [2:0] OCT_MAX = 3'd6;

    localparam logic [7:0] SC_BRK     = 8'hF0;
    localparam logic [7:0] SC_EXT     = 8'hE0;
    localparam logic [7:0] SC_BAT_OK  = 8'hAA;
    localparam logic [7:0] SC_ACK     = 8'hFA;
    localparam logic [7:0] SC_RESEND  = 8'hFE;
    localparam logic [7:0] SC_ERR_LO  = 8'h00;
    localparam logic [7:0] SC_ERR_HI  = 8'hFF;
    localparam logic [7:0] SC_OCT_DN  = 8'h1A;
    localparam logic [7:0] SC_OCT_UP  = 8'h22;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BRK     = 2'd1,
        ST_EXT     = 2'd2,
        ST_EXT_BRK = 2'd3
    } ps2_state_t;

endpackage

// File: rtl/ps2_note_lut.sv
// Scan-code (Set 2) to semitone lookup for one octave of piano keys.
// Purely combinational so it can be shared with the LCD note display.
module ps2_note_lut (
    input  logic [7:0] i_code,
    output logic       o_hit,
    output logic [3:0] o_semitone
);

    // Map the twelve note keys onto semitones 0..11; anything else misses.
    always_comb begin
        o_hit      = 1'b1;
        o_semitone = 4'd0;
        case (i_code)
            8'h1C:   o_semitone = 4'd0;
            8'h1D:   o_semitone = 4'd1;
            8'h1B:   o_semitone = 4'd2;
            8'h24:   o_semitone = 4'd3;
            8'h23:   o_semitone = 4'd4;
            8'h2B:   o_semitone = 4'd5;
            8'h2C:   o_semitone = 4'd6;
            8'h34:   o_semitone = 4'd7;
            8'h35:   o_semitone = 4'd8;
            8'h33:   o_semitone = 4'd9;
            8'h3C:   o_semitone = 4'd10;
            8'h3B:   o_semitone = 4'd11;
            default: begin
                o_hit      = 1'b0;
                o_semitone = 4'd0;
            end
        endcase
    end

endmodule

// File: rtl/ps2_key_tracker.sv
// Turns a stream of PS/2 Set 2 scan-code bytes into a held-key bitmap with
// a selectable octave window, note change events and an error strobe.
module ps2_key_tracker #(
    parameter int NUM_KEYS    = 88,
    parameter int OCT_DEFAULT = 3,
    parameter int TIMEOUT_CYC = 2500000
) (
    input  logic                iCLK,
    input  logic                iRST,
    input  logic                iSCAN_VALID,
    input  logic [7:0]          iSCAN_CODE,
    output logic [NUM_KEYS-1:0] oKEYS,
    output logic                oKEY_PRESSED,
    output logic [2:0]          oOCTAVE,
    output logic                oNOTE_EVT,
    output logic [6:0]          oNOTE_IDX,
    output logic                oNOTE_ON,
    output logic                oERR
);
    import ps2_keys_pkg::*;

    localparam int              CW      = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0]   TO_LAST = CW'(TIMEOUT_CYC - 1);
    localparam logic [2:0]      OCT_RST = 3'(OCT_DEFAULT);

    ps2_state_t          r_state, w_state_nxt;
    logic [NUM_KEYS-1:0] r_keys,  w_keys_nxt;
    logic [2:0]          r_oct,   w_oct_nxt;
    logic                r_evt,   w_evt_nxt;
    logic [6:0]          r_idx,   w_idx_nxt;
    logic                r_on,    w_on_nxt;
    logic                r_err,   w_err_nxt;
    logic                r_pressed;
    logic [CW-1:0]       r_tcnt,  w_tcnt_nxt;

    logic                w_hit;
    logic [3:0]          w_semi;
    logic [6:0]          w_key_idx;

    ps2_note_lut u_lut (
        .i_code     (iSCAN_CODE),
        .o_hit      (w_hit),
        .o_semitone (w_semi)
    );

    // Key index = 12 * octave + semitone, built from shifts (8x + 4x).
    assign w_key_idx = ({4'd0, r_oct} << 3) + ({4'd0, r_oct} << 2) + {3'd0, w_semi};

    // Next-state, key-map and event decode for each received byte.
    always_comb begin
        w_state_nxt = r_state;
        w_keys_nxt  = r_keys;
        w_oct_nxt   = r_oct;
        w_evt_nxt   = 1'b0;
        w_idx_nxt   = r_idx;
        w_on_nxt    = r_on;
        w_err_nxt   = 1'b0;
        if (iSCAN_VALID) begin
            case (iSCAN_CODE)
                SC_BAT_OK: begin
                    // Keyboard self-test passed: it was (re)plugged, start clean.
                    w_keys_nxt  = '0;
                    w_oct_nxt   = OCT_RST;
                    w_state_nxt = ST_IDLE;
                end
                SC_ERR_LO, SC_ERR_HI: begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
                SC_ACK, SC_RESEND: begin
                    // Protocol chatter only; keep any prefix in progress.
                    w_state_nxt = r_state;
                end
                default: begin
                    case (r_state)
                        ST_IDLE: begin
                            if (iSCAN_CODE == SC_BRK) begin
                                w_state_nxt = ST_BRK;
                            end else if (iSCAN_CODE == SC_EXT) begin
                                w_state_nxt = ST_EXT;
                            end else if (iSCAN_CODE == SC_OCT_DN) begin
                                if (r_oct != 3'd0) begin
                                    w_oct_nxt  = r_oct - 3'd1;
                                    w_keys_nxt = '0;
                                end else begin
                                    w_oct_nxt  = r_oct;
                                end
                            end else if (iSCAN_CODE == SC_OCT_UP) begin
                                if (r_oct < OCT_MAX) begin
                                    w_oct_nxt  = r_oct + 3'd1;
                                    w_keys_nxt = '0;
                                end else begin
                                    w_oct_nxt  = r_oct;
                                end
                            end else if (w_hit && !r_keys[w_key_idx]) begin
                                // Typematic repeats find the bit already set and fall through.
                                w_keys_nxt[w_key_idx] = 1'b1;
                                w_evt_nxt = 1'b1;
                                w_idx_nxt = w_key_idx;
                                w_on_nxt  = 1'b1;
                            end else begin
                                w_keys_nxt = r_keys;
                            end
                        end
                        ST_BRK: begin
                            // Octave key codes are unmapped in the LUT, so their break is a no-op.
                            if (w_hit && r_keys[w_key_idx]) begin
                                w_keys_nxt[w_key_idx] = 1'b0;
                                w_evt_nxt = 1'b1;
                                w_idx_nxt = w_key_idx;
                                w_on_nxt  = 1'b0;
                            end else begin
                                w_keys_nxt = r_keys;
                            end
                            w_state_nxt = ST_IDLE;
                        end
                        ST_EXT: begin
                            if (iSCAN_CODE == SC_BRK) begin
                                w_state_nxt = ST_EXT_BRK;
                            end else begin
                                w_state_nxt = ST_IDLE;
                            end
                        end
                        ST_EXT_BRK: begin
                            w_state_nxt = ST_IDLE;
                        end
                        default: begin
                            w_state_nxt = ST_IDLE;
                        end
                    endcase
                end
            endcase
        end else if ((r_state != ST_IDLE) && (r_tcnt == TO_LAST)) begin
            // Prefix abandoned by the keyboard: drop it without touching keys.
            w_state_nxt = ST_IDLE;
        end else begin
            w_state_nxt = r_state;
        end
    end

    // Prefix timeout counter: only advances while waiting inside a prefix.
    always_comb begin
        w_tcnt_nxt = r_tcnt;
        if (iSCAN_VALID || (r_state == ST_IDLE) || (r_tcnt == TO_LAST)) begin
            w_tcnt_nxt = '0;
        end else begin
            w_tcnt_nxt = r_tcnt + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state   <= ST_IDLE;
            r_keys    <= '0;
            r_oct     <= OCT_RST;
            r_evt     <= 1'b0;
            r_idx     <= 7'd0;
            r_on      <= 1'b0;
            r_err     <= 1'b0;
            r_pressed <= 1'b0;
            r_tcnt    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_keys    <= w_keys_nxt;
            r_oct     <= w_oct_nxt;
            r_evt     <= w_evt_nxt;
            r_idx     <= w_idx_nxt;
            r_on      <= w_on_nxt;
            r_err     <= w_err_nxt;
            r_pressed <= |w_keys_nxt;
            r_tcnt    <= w_tcnt_nxt;
        end
    end

    assign oKEYS        = r_keys;
    assign oKEY_PRESSED = r_pressed;
    assign oOCTAVE      = r_oct;
    assign oNOTE_EVT    = r_evt;
    assign oNOTE_IDX    = r_idx;
    assign oNOTE_ON     = r_on;
    assign oERR         = r_err;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Self-checking bench for ps2_key_tracker: directed scenarios followed by
// random byte traffic, all checked against a prefix-queue reference model.
module tb_ps2_key_tracker;

    localparam int TO = 16;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b1;
    logic        iSCAN_VALID = 1'b0;
    logic [7:0]  iSCAN_CODE = 8'h00;
    logic [87:0] oKEYS;
    logic        oKEY_PRESSED;
    logic [2:0]  oOCTAVE;
    logic        oNOTE_EVT;
    logic [6:0]  oNOTE_IDX;
    logic        oNOTE_ON;
    logic        oERR;

    ps2_key_tracker #(.NUM_KEYS(88), .OCT_DEFAULT(3), .TIMEOUT_CYC(TO)) dut (
        .iCLK(iCLK), .iRST(iRST), .iSCAN_VALID(iSCAN_VALID), .iSCAN_CODE(iSCAN_CODE),
        .oKEYS(oKEYS), .oKEY_PRESSED(oKEY_PRESSED), .oOCTAVE(oOCTAVE),
        .oNOTE_EVT(oNOTE_EVT), .oNOTE_IDX(oNOTE_IDX), .oNOTE_ON(oNOTE_ON), .oERR(oERR)
    );

    always #5 iCLK = ~iCLK;

    int n_checks = 0;
    int n_fail   = 0;
    int evt_seen = 0;

    // Reference model state
    logic [87:0] m_keys;
    int          m_oct;
    logic [7:0]  pfx[$];
    logic        e_evt, e_on, e_err;
    int          e_idx;

    logic [7:0] note_tab [12] = '{8'h1C, 8'h1D, 8'h1B, 8'h24, 8'h23, 8'h2B,
                                  8'h2C, 8'h34, 8'h35, 8'h33, 8'h3C, 8'h3B};

    task automatic chk(input string tag, input logic [87:0] obs, input logic [87:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int semi_of(input logic [7:0] b);
        for (int i = 0; i < 12; i++) if (note_tab[i] == b) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_keys = '0; m_oct = 3; pfx.delete();
        e_evt = 1'b0; e_on = 1'b0; e_err = 1'b0; e_idx = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        int s;
        e_evt = 1'b0; e_err = 1'b0;
        if (b == 8'hAA) begin
            m_keys = '0; m_oct = 3; pfx.delete();
        end else if (b == 8'h00 || b == 8'hFF) begin
            e_err = 1'b1; pfx.delete();
        end else if (b == 8'hFA || b == 8'hFE) begin
            e_err = 1'b0;
        end else if (pfx.size() == 0) begin
            if (b == 8'hF0 || b == 8'hE0) pfx.push_back(b);
            else if (b == 8'h1A) begin
                if (m_oct > 0) begin m_oct--; m_keys = '0; end
            end else if (b == 8'h22) begin
                if (m_oct < 6) begin m_oct++; m_keys = '0; end
            end else begin
                s = semi_of(b);
                if (s >= 0 && !m_keys[12*m_oct+s]) begin
                    m_keys[12*m_oct+s] = 1'b1;
                    e_evt = 1'b1; e_idx = 12*m_oct+s; e_on = 1'b1;
                end
            end
        end else if (pfx.size() == 1 && pfx[0] == 8'hF0) begin
            s = semi_of(b);
            if (s >= 0 && m_keys[12*m_oct+s]) begin
                m_keys[12*m_oct+s] = 1'b0;
                e_evt = 1'b1; e_idx = 12*m_oct+s; e_on = 1'b0;
            end
            pfx.delete();
        end else if (pfx.size() == 1 && b == 8'hF0) begin
            pfx.push_back(b);
        end else begin
            pfx.delete();
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".keys"}, oKEYS, m_keys);
        chk({tag, ".pressed"}, 88'(oKEY_PRESSED), 88'(|m_keys));
        chk({tag, ".oct"}, 88'(oOCTAVE), 88'(m_oct));
        chk({tag, ".evt"}, 88'(oNOTE_EVT), 88'(e_evt));
        chk({tag, ".err"}, 88'(oERR), 88'(e_err));
        if (e_evt) begin
            chk({tag, ".idx"}, 88'(oNOTE_IDX), 88'(e_idx));
            chk({tag, ".on"}, 88'(oNOTE_ON), 88'(e_on));
        end
    endtask

    task automatic send(input logic [7:0] b, input string tag);
        iSCAN_VALID = 1'b1;
        iSCAN_CODE  = b;
        @(posedge iCLK); #1;
        iSCAN_VALID = 1'b0;
        model_byte(b);
        if (oNOTE_EVT) evt_seen++;
        check_outputs(tag);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge iCLK); #1;
            e_evt = 1'b0; e_err = 1'b0;
            check_outputs("idle");
        end
    endtask

    task automatic do_reset();
        iRST = 1'b1;
        @(posedge iCLK); #1;
        @(posedge iCLK); #1;
        iRST = 1'b0;
        model_reset();
    endtask

    logic [7:0] pool [20] = '{8'h1C, 8'h1D, 8'h1B, 8'h24, 8'h23, 8'h2B, 8'h2C,
                              8'h34, 8'h35, 8'h33, 8'h3C, 8'h3B, 8'h1A, 8'h22,
                              8'hF0, 8'hF0, 8'hE0, 8'h15, 8'hFA, 8'hAA};
    int ev0;
    logic [7:0] rb;

    initial begin
        model_reset();
        do_reset();
        check_outputs("reset");
        chk("reset.idx", 88'(oNOTE_IDX), 88'd0);
        chk("reset.on", 88'(oNOTE_ON), 88'd0);

        // Basic make / break at octave 3
        send(8'h1C, "make1C");
        chk("make1C.bit36", 88'(oKEYS[36]), 88'd1);
        send(8'hF0, "brkpfx");
        send(8'h1C, "brk1C");
        chk("brk1C.bit36", 88'(oKEYS[36]), 88'd0);
        idle(2);

        // Typematic repeat gives a single event; octave up clears keys
        ev0 = evt_seen;
        send(8'h1C, "typ1"); send(8'h1C, "typ2"); send(8'h1C, "typ3");
        chk("typematic.evts", 88'(evt_seen - ev0), 88'd1);
        send(8'h22, "octup");
        chk("octup.oct", 88'(oOCTAVE), 88'd4);
        send(8'h1C, "make48");
        chk("make48.bit", 88'(oKEYS[48]), 88'd1);

        // Top of range and saturation
        send(8'h22, "up5"); send(8'h22, "up6");
        send(8'h3B, "make83");
        chk("make83.bit", 88'(oKEYS[83]), 88'd1);
        send(8'h22, "upsat");
        chk("upsat.bit83", 88'(oKEYS[83]), 88'd1);
        for (int i = 0; i < 6; i++) send(8'h1A, "down");
        chk("down.oct0", 88'(oOCTAVE), 88'd0);
        send(8'h1A, "downsat");

        // Extended sequences never touch notes
        send(8'h1B, "make2");
        send(8'hE0, "e0"); send(8'h1C, "ext1C");
        send(8'hE0, "e0b"); send(8'hF0, "e0f0"); send(8'h1B, "extbrk1B");
        chk("ext.bit2", 88'(oKEYS[2]), 88'd1);
        send(8'h1C, "make0");
        chk("make0.bit", 88'(oKEYS[0]), 88'd1);

        // Prefix timeout: the 1D afterwards is a make, not a break
        send(8'hF0, "topfx");
        idle(TO + 4);
        pfx.delete();
        send(8'h1D, "tomake");
        chk("tomake.bit1", 88'(oKEYS[1]), 88'd1);

        // ACK/RESEND keep the prefix; BAT OK and error bytes
        send(8'hF0, "ackpfx"); send(8'hFA, "ack"); send(8'h1D, "ackbrk");
        send(8'h22, "o1"); send(8'h22, "o2"); send(8'h22, "o3"); send(8'h22, "o4");
        send(8'h1C, "h1C"); send(8'h23, "h23");
        send(8'hAA, "bat");
        chk("bat.oct", 88'(oOCTAVE), 88'd3);
        send(8'hFF, "errff");
        chk("errff.pulse", 88'(oERR), 88'd1);
        idle(1);
        send(8'hF0, "errpfx"); send(8'h00, "err00"); send(8'h1C, "after_err");

        // Reset between F0 and its code
        send(8'hF0, "rstpfx");
        do_reset();
        send(8'h1C, "rstmake");
        chk("rstmake.bit36", 88'(oKEYS[36]), 88'd1);

        // Random traffic with short gaps
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 40) == 0) rb = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
            else rb = pool[$urandom_range(0, 19)];
            send(rb, "rand");
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
